demux1x2: RTL
=============

# demux1x2

Receive-side counterpart of the 2:1 time-interleaving mux. Takes the single 8-bit lane-interleaved stream (lane 0 slot, lane 1 slot, repeating) and splits it back into two 8-bit lanes. Each lane pair is re-aligned so both words are presented together with their own valid flags. Sits directly after the mux output (or after the link carrying it), on the same clock.

## Interface
Parameters:
- LATENCIA_ENTRADA, 1: number of active clock edges after reset release that are ignored before the first lane-0 slot. Range 0–3. Default 1 matches the mux's one-cycle output register.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low. 0 = held in reset; 1 = operate.
- Entrada  input  8  interleaved data word.
- validEntrada  input  1  qualifies Entrada in the current slot.
- Salida0  output  8  lane-0 word of the last completed pair.
- Salida1  output  8  lane-1 word of the last completed pair.
- validSalida0  output  1  Salida0 carries a valid word.
- validSalida1  output  1  Salida1 carries a valid word.
- par_listo  output  1  one-cycle pulse: the outputs were updated on this edge.
- cuenta0  output  8  running count of valid lane-0 words accepted.
- cuenta1  output  8  running count of valid lane-1 words accepted.

## Operation
- Reset (reset=0, asynchronous):
  - all outputs 0, hold register 0, hold-valid 0;
  - skip counter = LATENCIA_ENTRADA;
  - FSM goes to SALTO, or to FASE0 if LATENCIA_ENTRADA=0.
- FSM states:
  - SALTO: Entrada ignored. Each edge decrements the skip counter. The edge that reaches 0 moves to FASE0.
  - FASE0 (lane-0 slot): on the edge, hold <= validEntrada ? Entrada : 0 and hold_valid <= validEntrada. If validEntrada, cuenta0 increments. Next state FASE1.
  - FASE1 (lane-1 slot): on the edge, both output words and their valids update together:
    - Salida0 <= hold; validSalida0 <= hold_valid;
    - Salida1 <= validEntrada ? Entrada : 0; validSalida1 <= validEntrada;
    - par_listo <= 1; cuenta1 increments if validEntrada.
    - Next state FASE0.
- par_listo is cleared on every edge that is not a FASE1 edge.
- Lane alternation is strict: the FSM toggles every slot whether or not the data is valid. This mirrors the mux, which toggles unconditionally.
- Invalid slots always produce data 0 with valid 0; stale data is never passed through.
- Counters are 8-bit unsigned and wrap 255 -> 0 without a flag.
- Salida0/1 and their valids hold their values between updates, i.e. for 2 cycles per pair.

## Timing
- Latency:
  - lane-0 word sampled at edge k appears on Salida0 at edge k+1;
  - lane-1 word sampled at edge k+1 appears on Salida1 at that same edge k+1.
- After reset release, the first FASE0 edge is edge LATENCIA_ENTRADA+1, and the first par_listo is at edge LATENCIA_ENTRADA+2.
- Reset asserted mid-pair, including in FASE1 with a lane-0 word held: the held word is discarded and outputs go to 0 immediately (asynchronous). After release, alignment restarts from SALTO.
- validEntrada toggling every cycle is legal; each slot is judged independently.
- There is no backpressure. The block accepts one word every cycle.

## Test plan
- Reset: reset=0 with random Entrada/validEntrada -> all outputs 0, counts 0. Release -> first edge ignored (default parameter), no par_listo.
- Basic pair: after the skip edge, drive 0xA5 (valid) then 0x3C (valid) -> at the second edge Salida0=0xA5, Salida1=0x3C, both valids 1, par_listo=1 for one cycle; cuenta0=cuenta1=1.
- Invalid slot: 0x77 with validEntrada=0 in FASE0, then 0x12 valid -> Salida0=0, validSalida0=0, Salida1=0x12, validSalida1=1; cuenta0 unchanged.
- Back-to-back mux loopback: mux2x1 fed lanes 0x10..0x1F / 0x20..0x2F, shared clk/reset -> demux reproduces both sequences in order, pairwise aligned, no slip over 16 pairs.
- Counter wrap: 256 valid lane-1 words -> cuenta1 returns to 0; cuenta0 is unaffected if lane 0 is held invalid.
- Mid-pair reset: assert reset between FASE0 (0x55 held) and FASE1 -> outputs 0 at once. After release, the next pair shows no trace of 0x55, and the phase restarts after LATENCIA_ENTRADA skip edges.

Source files
------------

// File: rtl/demux1x2.sv
`default_nettype none
// ============================================================================
// Module   : demux1x2
// Purpose  : Receive-side 1:2 time-deinterleaver. Splits a single 8-bit
//            lane-interleaved stream (lane 0 slot, lane 1 slot, repeating)
//            back into two lanes, presenting each pair together with its
//            own valid flags and keeping per-lane counts of valid words.
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous, active-low
//            Entrada      - interleaved data word
//            validEntrada - qualifies Entrada in the current slot
//            Salida0/1    - lane-0 / lane-1 words of the last completed pair
//            validSalida0/1 - valid flags for Salida0/1
//            par_listo    - one-cycle pulse when the pair outputs update
//            cuenta0/1    - wrapping counts of valid lane-0 / lane-1 words
// Revision : 1.0 - initial release
// ============================================================================
module demux1x2 #(
    parameter int unsigned LATENCIA_ENTRADA = 1   // 0..3 edges ignored after reset
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Entrada,
    input  logic       validEntrada,
    output logic [7:0] Salida0,
    output logic [7:0] Salida1,
    output logic       validSalida0,
    output logic       validSalida1,
    output logic       par_listo,
    output logic [7:0] cuenta0,
    output logic [7:0] cuenta1
);

    localparam logic [1:0] SALTO = 2'd0;
    localparam logic [1:0] FASE0 = 2'd1;
    localparam logic [1:0] FASE1 = 2'd2;

    localparam logic [1:0] c_skip_init  = LATENCIA_ENTRADA[1:0];
    // With no input latency to absorb, the first edge is already a lane-0 slot.
    localparam logic [1:0] c_state_init = (LATENCIA_ENTRADA == 0) ? FASE0 : SALTO;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [1:0] r_skip;
    logic [7:0] r_hold;
    logic       r_hold_valid;

    logic       w_skip_dec;
    logic       w_load_hold;
    logic       w_load_pair;
    logic [7:0] w_din_masked;

    // Invalid slots are forced to zero so stale data never reaches a lane.
    assign w_din_masked = validEntrada ? Entrada : 8'h00;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_state_init;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    // Lane alternation is unconditional: validity never stalls the phase.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SALTO:   w_state_next = (r_skip <= 2'd1) ? FASE0 : SALTO;
            FASE0:   w_state_next = FASE1;
            FASE1:   w_state_next = FASE0;
            default: w_state_next = FASE0;
        endcase
    end

    // ------------------------------------------------------ state decodes
    always_comb begin
        w_skip_dec  = 1'b0;
        w_load_hold = 1'b0;
        w_load_pair = 1'b0;
        case (r_state)
            SALTO:   w_skip_dec  = 1'b1;
            FASE0:   w_load_hold = 1'b1;
            FASE1:   w_load_pair = 1'b1;
            default: w_load_hold = 1'b0;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skip       <= c_skip_init;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
            Salida0      <= 8'h00;
            Salida1      <= 8'h00;
            validSalida0 <= 1'b0;
            validSalida1 <= 1'b0;
            par_listo    <= 1'b0;
            cuenta0      <= 8'h00;
            cuenta1      <= 8'h00;
        end else begin
            par_listo <= w_load_pair;

            if (w_skip_dec && (r_skip != 2'd0)) begin
                r_skip <= r_skip - 2'd1;
            end

            if (w_load_hold) begin
                r_hold       <= w_din_masked;
                r_hold_valid <= validEntrada;
                if (validEntrada) begin
                    cuenta0 <= cuenta0 + 8'd1;
                end
            end

            // Both lanes update on the same edge so the pair stays aligned.
            if (w_load_pair) begin
                Salida0      <= r_hold;
                validSalida0 <= r_hold_valid;
                Salida1      <= w_din_masked;
                validSalida1 <= validEntrada;
                if (validEntrada) begin
                    cuenta1 <= cuenta1 + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
